// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with one word per line.
// It sits between the CPU load/store stage and a multi-cycle busy_wait data memory.
module dcache_ctrl #(
   parameter int unsigned ADDR_W  = 7,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned INDEX_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [DATA_W-1:0] cpu_write_data,
   output logic [DATA_W-1:0] cpu_read_data,
   output logic              cpu_busy_wait,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic              mem_busy_wait
);
   localparam int unsigned TAG_W = ADDR_W - INDEX_W;
   localparam int unsigned LINES = 1 << INDEX_W;

   typedef enum logic [2:0] {IDLE, WB, GAP, FETCH, FILL} state_t;

   state_t              state, state_next;
   logic [LINES-1:0]    valid, dirty;
   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [DATA_W-1:0]   data_mem [LINES];
   logic                seen_busy;
   logic [DATA_W-1:0]   fetch_data;
   logic [INDEX_W-1:0]  index;
   logic [TAG_W-1:0]    tag;
   logic                req_read, req_write, req, hit, mem_done, store_hit;

   always_comb begin
      index     = cpu_address[INDEX_W-1:0];
      tag       = cpu_address[ADDR_W-1:INDEX_W];
      // read and write together is not a request at all
      req_read  = cpu_read & ~cpu_write;
      req_write = cpu_write & ~cpu_read;
      req       = req_read | req_write;
      hit       = valid[index] && (tag_mem[index] == tag);
      mem_done  = seen_busy && !mem_busy_wait;
      store_hit = (state == IDLE) && req_write && hit;
   end

   always_comb begin
      state_next     = state;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      cpu_read_data  = '0;
      cpu_busy_wait  = (state != IDLE) || (req && !hit);
      if (state == IDLE && req_read && hit)
         cpu_read_data = data_mem[index];
      case (state)
         IDLE: begin
            if (req && !hit)
               state_next = (valid[index] && dirty[index]) ? WB : FETCH;
         end
         WB: begin
            mem_write      = 1'b1;
            mem_address    = {tag_mem[index], index};
            mem_write_data = data_mem[index];
            if (mem_done)
               state_next = GAP;
         end
         GAP: state_next = FETCH;
         FETCH: begin
            mem_read    = 1'b1;
            mem_address = cpu_address;
            if (mem_done)
               state_next = FILL;
         end
         FILL: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         valid      <= '0;
         dirty      <= '0;
         seen_busy  <= 1'b0;
         fetch_data <= '0;
      end else begin
         state <= state_next;
         // busy must be seen high before a low sample counts as completion
         if (state_next != state)
            seen_busy <= 1'b0;
         else if (mem_busy_wait)
            seen_busy <= 1'b1;
         if (state == FETCH && mem_done)
            fetch_data <= mem_read_data;
         if (state == FILL) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
         end else if (store_hit) begin
            dirty[index] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if (state == FILL) begin
            tag_mem[index]  <= tag;
            data_mem[index] <= fetch_data;
         end else if (store_hit) begin
            data_mem[index] <= cpu_write_data;
         end
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl against a 128x16 busy_wait memory model.
// Each task drives one scenario and checks its expected values inline.
module tb_dcache_ctrl;
   localparam int unsigned MEM_LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_read = 1'b0, cpu_write = 1'b0;
   logic [6:0]  cpu_address = '0;
   logic [15:0] cpu_write_data = '0;
   logic [15:0] cpu_read_data;
   logic        cpu_busy_wait;
   logic        mem_read, mem_write;
   logic [6:0]  mem_address;
   logic [15:0] mem_write_data;
   logic [15:0] mem_read_data = '0;
   logic        mem_busy_wait = 1'b0;

   logic [15:0] mem [128];
   logic        prev_req = 1'b0;
   int          busy_cnt = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   dcache_ctrl #(.ADDR_W(7), .DATA_W(16), .INDEX_W(3)) dut (
      .clk(clk), .rst(rst),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
      .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
      .cpu_busy_wait(cpu_busy_wait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .mem_busy_wait(mem_busy_wait)
   );

   // memory: a rising request starts MEM_LAT busy cycles, then the access completes
   always @(posedge clk) begin
      prev_req <= mem_read | mem_write;
      if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) begin
            mem_busy_wait <= 1'b0;
            if (mem_write) mem[mem_address] <= mem_write_data;
            if (mem_read)  mem_read_data <= mem[mem_address];
         end
      end else if ((mem_read | mem_write) && !prev_req) begin
         mem_busy_wait <= 1'b1;
         busy_cnt      <= MEM_LAT;
      end
   end

   task automatic wait_ready(output int cycles);
      cycles = 0;
      while (cpu_busy_wait === 1'b1 && cycles < 100) begin
         @(negedge clk); #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      total++; if (cpu_busy_wait !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", cpu_busy_wait); end
      total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
      total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
      total++; if (mem_address !== 7'h00) begin bad++; $display("FAIL reset_mem_address: got %h want 00", mem_address); end
      total++; if (mem_write_data !== 16'h0000) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0000", mem_write_data); end
      total++; if (cpu_read_data !== 16'h0000) begin bad++; $display("FAIL reset_rdata: got %h want 0000", cpu_read_data); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read_miss();
      int cycles, reads, writes;
      cycles = 0; reads = 0; writes = 0;
      cpu_read = 1'b1; cpu_address = 7'h05;
      #1;
      total++; if (cpu_busy_wait !== 1'b1) begin bad++; $display("FAIL miss_busy: got %b want 1", cpu_busy_wait); end
      while (cpu_busy_wait === 1'b1 && cycles < 100) begin
         @(negedge clk); #1;
         cycles++;
         if (mem_write) writes++;
         if (mem_read) begin
            reads++;
            total++; if (mem_address !== 7'h05) begin bad++; $display("FAIL miss_addr: got %h want 05", mem_address); end
         end
      end
      total++; if (cycles != 7) begin bad++; $display("FAIL miss_latency: got %0d want 7", cycles); end
      total++; if (reads != 5) begin bad++; $display("FAIL miss_read_cycles: got %0d want 5", reads); end
      total++; if (writes != 0) begin bad++; $display("FAIL miss_no_write: got %0d want 0", writes); end
      total++; if (cpu_read_data !== 16'hBEEF) begin bad++; $display("FAIL miss_rdata: got %h want beef", cpu_read_data); end
      @(negedge clk);
      cpu_read = 1'b0;
   endtask

   task automatic test_read_hit();
      @(negedge clk);
      cpu_read = 1'b1; cpu_address = 7'h05;
      #1;
      total++; if (cpu_busy_wait !== 1'b0) begin bad++; $display("FAIL hit_busy: got %b want 0", cpu_busy_wait); end
      total++; if (cpu_read_data !== 16'hBEEF) begin bad++; $display("FAIL hit_rdata: got %h want beef", cpu_read_data); end
      @(negedge clk); #1;
      total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL hit_mem_read: got %b want 0", mem_read); end
      cpu_read = 1'b0;
   endtask

   task automatic test_write_hit();
      @(negedge clk);
      cpu_write = 1'b1; cpu_address = 7'h05; cpu_write_data = 16'h1234;
      #1;
      total++; if (cpu_busy_wait !== 1'b0) begin bad++; $display("FAIL whit_busy: got %b want 0", cpu_busy_wait); end
      @(negedge clk);
      cpu_write = 1'b0; cpu_read = 1'b1;
      #1;
      total++; if (cpu_busy_wait !== 1'b0) begin bad++; $display("FAIL whit_read_busy: got %b want 0", cpu_busy_wait); end
      total++; if (cpu_read_data !== 16'h1234) begin bad++; $display("FAIL whit_rdata: got %h want 1234", cpu_read_data); end
      total++; if (mem[5] !== 16'hBEEF) begin bad++; $display("FAIL whit_mem_untouched: got %h want beef", mem[5]); end
      @(negedge clk);
      cpu_read = 1'b0;
   endtask

   task automatic test_dirty_evict();
      int cycles, last_w, first_r;
      logic gap_ok;
      cycles = 0; last_w = -1; first_r = -1; gap_ok = 1'b0;
      @(negedge clk);
      cpu_read = 1'b1; cpu_address = 7'h0D;
      #1;
      total++; if (cpu_busy_wait !== 1'b1) begin bad++; $display("FAIL evict_busy: got %b want 1", cpu_busy_wait); end
      while (cpu_busy_wait === 1'b1 && cycles < 100) begin
         @(negedge clk); #1;
         cycles++;
         if (mem_write) begin
            last_w = cycles;
            total++; if ({mem_address, mem_write_data} !== {7'h05, 16'h1234}) begin bad++; $display("FAIL evict_wb: got %h/%h want 05/1234", mem_address, mem_write_data); end
         end
         if (mem_read) begin
            if (first_r < 0) first_r = cycles;
            total++; if (mem_address !== 7'h0D) begin bad++; $display("FAIL evict_fetch_addr: got %h want 0d", mem_address); end
         end
         if (last_w > 0 && cycles == last_w + 1 && !mem_read && !mem_write) gap_ok = 1'b1;
      end
      total++; if (cycles != 13) begin bad++; $display("FAIL evict_latency: got %0d want 13", cycles); end
      total++; if (first_r - last_w != 2) begin bad++; $display("FAIL evict_gap: got %0d want 2", first_r - last_w); end
      total++; if (gap_ok !== 1'b1) begin bad++; $display("FAIL evict_gap_low: got %b want 1", gap_ok); end
      total++; if (mem[5] !== 16'h1234) begin bad++; $display("FAIL evict_mem: got %h want 1234", mem[5]); end
      total++; if (cpu_read_data !== 16'hCAFE) begin bad++; $display("FAIL evict_rdata: got %h want cafe", cpu_read_data); end
      @(negedge clk);
      cpu_read = 1'b0;
   endtask

   task automatic test_write_miss();
      int cycles;
      @(negedge clk);
      cpu_write = 1'b1; cpu_address = 7'h13; cpu_write_data = 16'hA5A5;
      #1;
      wait_ready(cycles);
      total++; if (cycles != 7) begin bad++; $display("FAIL wmiss_latency: got %0d want 7", cycles); end
      @(negedge clk);
      cpu_write = 1'b0; cpu_read = 1'b1;
      #1;
      total++; if (cpu_busy_wait !== 1'b0) begin bad++; $display("FAIL wmiss_busy: got %b want 0", cpu_busy_wait); end
      total++; if (cpu_read_data !== 16'hA5A5) begin bad++; $display("FAIL wmiss_rdata: got %h want a5a5", cpu_read_data); end
      total++; if (mem[8'h13] !== 16'h1013) begin bad++; $display("FAIL wmiss_mem: got %h want 1013", mem[8'h13]); end
      @(negedge clk);
      cpu_read = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [6:0]  addrs [3];
      logic [15:0] exp   [3];
      addrs = '{7'h0D, 7'h13, 7'h0D};
      exp   = '{16'hCAFE, 16'hA5A5, 16'hCAFE};
      cpu_read = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cpu_address = addrs[i];
         #1;
         total++; if ({cpu_busy_wait, cpu_read_data} !== {1'b0, exp[i]}) begin bad++; $display("FAIL b2b_%0d: got %b/%h want 0/%h", i, cpu_busy_wait, cpu_read_data, exp[i]); end
         @(negedge clk);
      end
      cpu_read = 1'b0;
   endtask

   task automatic test_reset_mid_fetch();
      int cycles;
      @(negedge clk);
      cpu_read = 1'b1; cpu_address = 7'h22;
      repeat (3) @(negedge clk);
      #1;
      total++; if ({mem_read, mem_address} !== {1'b1, 7'h22}) begin bad++; $display("FAIL mid_fetch_active: got %b/%h want 1/22", mem_read, mem_address); end
      rst = 1'b0; cpu_read = 1'b0;
      @(negedge clk); #1;
      total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL mid_rst_mem_read: got %b want 0", mem_read); end
      total++; if (cpu_busy_wait !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", cpu_busy_wait); end
      total++; if (mem_address !== 7'h00) begin bad++; $display("FAIL mid_rst_addr: got %h want 00", mem_address); end
      rst = 1'b1;
      repeat (10) @(negedge clk);
      cpu_read = 1'b1; cpu_address = 7'h0D;
      #1;
      total++; if (cpu_busy_wait !== 1'b1) begin bad++; $display("FAIL post_rst_miss: got %b want 1", cpu_busy_wait); end
      wait_ready(cycles);
      total++; if (cycles != 7) begin bad++; $display("FAIL post_rst_latency: got %0d want 7", cycles); end
      total++; if (cpu_read_data !== 16'hCAFE) begin bad++; $display("FAIL post_rst_rdata: got %h want cafe", cpu_read_data); end
      @(negedge clk);
      cpu_address = 7'h13;
      #1;
      wait_ready(cycles);
      total++; if (cycles != 7) begin bad++; $display("FAIL post_rst_clean: got %0d want 7", cycles); end
      total++; if (cpu_read_data !== 16'h1013) begin bad++; $display("FAIL post_rst_rdata2: got %h want 1013", cpu_read_data); end
      @(negedge clk);
      cpu_read = 1'b0;
   endtask

   task automatic test_both_req();
      @(negedge clk);
      cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 7'h05; cpu_write_data = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if ({cpu_busy_wait, mem_read, mem_write} !== 3'b000) begin bad++; $display("FAIL both_req_%0d: got %b want 000", i, {cpu_busy_wait, mem_read, mem_write}); end
         @(negedge clk);
      end
      cpu_write = 1'b0; cpu_address = 7'h0D;
      #1;
      total++; if ({cpu_busy_wait, cpu_read_data} !== {1'b0, 16'hCAFE}) begin bad++; $display("FAIL both_req_nochange: got %b/%h want 0/cafe", cpu_busy_wait, cpu_read_data); end
      @(negedge clk);
      cpu_read = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 16'h1000 + 16'(i);
      mem[5]  = 16'hBEEF;
      mem[13] = 16'hCAFE;
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_hit();
      test_dirty_evict();
      test_write_miss();
      test_back_to_back();
      test_reset_mid_fetch();
      test_both_req();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
